// File: rtl/countervar_pkg.sv
// Shared types and helpers for the countervar_n counter family.
// The state encoding, parity helper and default width live here.
package countervar_pkg;

    localparam int CV_DEFAULT_WIDTH = 8;
    localparam int CV_MAX_WIDTH     = 32;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cv_state_e;

    // Even parity of a value zero-extended to the widest supported counter.
    function automatic logic cv_parity(input logic [CV_MAX_WIDTH-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/countervar_prescaler.sv
// Rate divider: emits a one-cycle tick every PRESCALE enabled clk_50 cycles.
// A clr pulse restarts the divide sequence from zero.
module countervar_prescaler
    import countervar_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk_50,
    input  logic reset,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // With PRESCALE = 1 the divider sits at zero, so tick simply follows enable.
    assign tick = enable && (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/countervar_n.sv
// Prescaled up/down modulo counter with load, one-shot stop and tc/done flags.
// Optional registered parity output when COUNTERVAR_PARITY_EN is defined.
module countervar_n
    import countervar_pkg::*;
#(
    parameter int WIDTH     = CV_DEFAULT_WIDTH,
    parameter int PRESCALE  = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             load_1,
    input  logic [WIDTH-1:0] count_in,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] mod_max,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
`ifdef COUNTERVAR_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

    logic             tick;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    cv_state_e        state_q;
    cv_state_e        state_d;

    countervar_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_50 (clk_50),
        .reset  (reset),
        .enable (enable),
        .clr    (~load_1),
        .tick   (tick)
    );

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        state_d = state_q;
        if (!load_1) begin
            // A load always wins, even over a boundary tick in the same cycle.
            count_d = count_in;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && tick) begin
            if (up_dn) begin
                if (count_q >= mod_max) begin
                    tc_d = 1'b1;
                    if (one_shot) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (one_shot) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = mod_max;
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            count_q <= RST_COUNT;
            tc_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = (state_q == ST_DONE);

`ifdef COUNTERVAR_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Computed from the next count so it lines up with count after the edge.
    always_comb begin
        parity_d = cv_parity(CV_MAX_WIDTH'(count_d));
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            parity_q <= cv_parity(CV_MAX_WIDTH'(RST_COUNT));
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule
